// File: rtl/keccak_msg_feeder_pkg.sv
// Shared types and widths for the keccak message feeder.
// State encoding and word geometry used by the feeder top and the byte assembler.
package keccak_feed_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_NUM_W     = 2;

  typedef enum logic [2:0] {
    CRST,
    COLLECT,
    EXTRA,
    DRAIN,
    WAIT
  } feed_state_t;

endpackage

// File: rtl/keccak_msg_feeder_if.sv
// Byte-stream input and keccak core word interface of the message feeder.
// Byte side: a byte moves when s_valid && s_ready. Word side: a word moves when
// k_in_ready && !k_buffer_full; k_in/k_is_last/k_byte_num hold until then.
interface keccak_msg_feeder_if;
  import keccak_feed_pkg::*;

  logic [7:0]            s_byte;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic [WORD_W-1:0]     k_in;
  logic                  k_in_ready;
  logic                  k_is_last;
  logic [BYTE_NUM_W-1:0] k_byte_num;
  logic                  k_buffer_full;
  logic                  k_out_ready;
  logic                  k_reset;

  modport master (
    input  s_byte, s_valid, s_last, k_buffer_full, k_out_ready,
    output s_ready, k_in, k_in_ready, k_is_last, k_byte_num, k_reset
  );

  modport slave (
    output s_byte, s_valid, s_last, k_buffer_full, k_out_ready,
    input  s_ready, k_in, k_in_ready, k_is_last, k_byte_num, k_reset
  );

endinterface

// File: rtl/keccak_word_assembler.sv
// Collects up to three bytes and presents them, together with the incoming
// byte, as an MSB-first left-aligned word.
module keccak_word_assembler
  import keccak_feed_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic              flush,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic [2:0]        nbytes,
  output logic              word_done,
  output logic [1:0]        cnt
);

  logic [23:0] asm_q;
  logic [1:0]  cnt_q;

  assign word_done = push && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign nbytes    = {1'b0, cnt_q} + 3'd1;
  assign cnt       = cnt_q;

  // A full word or the message's last byte empties the assembler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      if (word_done || flush) begin
        asm_q <= '0;
        cnt_q <= '0;
      end else begin
        asm_q <= {asm_q[15:0], byte_in};
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    word = '0;
    case (cnt_q)
      2'd0:    word = {byte_in, 24'h0};
      2'd1:    word = {asm_q[7:0], byte_in, 16'h0};
      2'd2:    word = {asm_q[15:0], byte_in, 8'h0};
      default: word = {asm_q, byte_in};
    endcase
  end

endmodule

// File: rtl/keccak_msg_feeder.sv
// Streams message bytes into the keccak core as 32-bit words, resetting the
// core before each message and waiting for its digest.
module keccak_msg_feeder
  import keccak_feed_pkg::*;
#(
  parameter int RESET_CYCLES = 1,
  parameter int LEN_W        = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  keccak_msg_feeder_if.master bus,
  output logic                busy,
  output logic                msg_done,
  output logic [LEN_W-1:0]    msg_len,
  output feed_state_t         dbg_state
);

  localparam logic [3:0]       RST_LAST = 4'(RESET_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = '1;

  feed_state_t           state_q, state_d;
  logic [3:0]            rst_cnt_q, rst_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [WORD_W-1:0]     out_word_q, out_word_d;
  logic                  out_last_q, out_last_d;
  logic [BYTE_NUM_W-1:0] out_bnum_q, out_bnum_d;
  logic [LEN_W-1:0]      msg_len_q, msg_len_d;
  logic                  alive_q;
  logic                  done;

  logic                  word_acc, s_rdy, byte_acc;
  logic [WORD_W-1:0]     asm_word;
  logic [2:0]            asm_nbytes;
  logic                  asm_done;
  logic [1:0]            asm_cnt;

  assign word_acc = out_valid_q && !bus.k_buffer_full;
  assign s_rdy    = (state_q == COLLECT) && (!out_valid_q || word_acc);
  assign byte_acc = bus.s_valid && s_rdy;

  keccak_word_assembler u_asm (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (state_q == CRST),
    .push      (byte_acc),
    .flush     (bus.s_last),
    .byte_in   (bus.s_byte),
    .word      (asm_word),
    .nbytes    (asm_nbytes),
    .word_done (asm_done),
    .cnt       (asm_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CRST;
      rst_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_last_q  <= 1'b0;
      out_bnum_q  <= '0;
      msg_len_q   <= '0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_last_q  <= out_last_d;
      out_bnum_q  <= out_bnum_d;
      msg_len_q   <= msg_len_d;
      alive_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    out_valid_d = out_valid_q && !word_acc;
    out_word_d  = out_word_q;
    out_last_d  = out_last_q;
    out_bnum_d  = out_bnum_q;
    msg_len_d   = msg_len_q;
    done        = 1'b0;
    case (state_q)
      CRST: begin
        out_valid_d = 1'b0;
        out_word_d  = '0;
        out_last_d  = 1'b0;
        out_bnum_d  = '0;
        msg_len_d   = '0;
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = '0;
          state_d   = COLLECT;
        end else begin
          rst_cnt_d = rst_cnt_q + 4'd1;
        end
      end
      COLLECT: begin
        if (byte_acc) begin
          if (msg_len_q != LEN_MAX) msg_len_d = msg_len_q + LEN_W'(1);
          // A last byte that fills the word still needs a zero-length final word.
          if (bus.s_last) begin
            out_valid_d = 1'b1;
            out_word_d  = asm_word;
            out_last_d  = !asm_nbytes[2];
            out_bnum_d  = asm_nbytes[2] ? '0 : asm_nbytes[1:0];
            state_d     = asm_nbytes[2] ? EXTRA : DRAIN;
          end else if (asm_done) begin
            out_valid_d = 1'b1;
            out_word_d  = asm_word;
            out_last_d  = 1'b0;
            out_bnum_d  = '0;
          end
        end
      end
      EXTRA: begin
        if (!out_valid_q || word_acc) begin
          out_valid_d = 1'b1;
          out_word_d  = '0;
          out_last_d  = 1'b1;
          out_bnum_d  = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (word_acc) state_d = WAIT;
      end
      WAIT: begin
        if (bus.k_out_ready) begin
          done      = 1'b1;
          msg_len_d = '0;
          state_d   = CRST;
        end
      end
      default: state_d = CRST;
    endcase
  end

  assign bus.s_ready    = s_rdy;
  assign bus.k_in       = out_word_q;
  assign bus.k_in_ready = out_valid_q;
  assign bus.k_is_last  = out_last_q;
  assign bus.k_byte_num = out_bnum_q;
  assign bus.k_reset    = (state_q == CRST);

  assign msg_done  = done;
  assign msg_len   = msg_len_q;
  assign dbg_state = state_q;
  // alive_q keeps busy low while reset_n is asserted even though the state is CRST.
  assign busy      = alive_q && !((state_q == COLLECT) && (asm_cnt == 2'd0) && (msg_len_q == '0));

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Directed and randomized message bench for keccak_msg_feeder with a word-list
// reference model and an expected-word scoreboard.
module tb_keccak_msg_feeder;
  import keccak_feed_pkg::*;

  localparam int RST_CYC  = 1;
  localparam int TB_LEN_W = 5;
  localparam int LEN_SAT  = (1 << TB_LEN_W) - 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [7:0]          s_byte;
  logic                s_valid, s_last, s_ready;
  logic [31:0]         k_in;
  logic                k_in_ready, k_is_last, k_reset;
  logic [1:0]          k_byte_num;
  logic                k_buffer_full, k_out_ready;
  logic                busy, msg_done;
  logic [TB_LEN_W-1:0] msg_len;
  feed_state_t         dbg_state;

  keccak_msg_feeder_if bus_if ();

  assign bus_if.s_byte        = s_byte;
  assign bus_if.s_valid       = s_valid;
  assign bus_if.s_last        = s_last;
  assign bus_if.k_buffer_full = k_buffer_full;
  assign bus_if.k_out_ready   = k_out_ready;
  assign s_ready    = bus_if.s_ready;
  assign k_in       = bus_if.k_in;
  assign k_in_ready = bus_if.k_in_ready;
  assign k_is_last  = bus_if.k_is_last;
  assign k_byte_num = bus_if.k_byte_num;
  assign k_reset    = bus_if.k_reset;

  keccak_msg_feeder #(.RESET_CYCLES(RST_CYC), .LEN_W(TB_LEN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_if.master),
    .busy      (busy),
    .msg_done  (msg_done),
    .msg_len   (msg_len),
    .dbg_state (dbg_state)
  );

  int          tests = 0;
  int          fails = 0;
  logic [34:0] exp_q[$];
  logic [34:0] exp_e, prev_word;
  logic [7:0]  msg_buf[64];
  bit          prev_hold = 0;
  bit          done_allowed = 0;
  bit          rand_bf = 0;
  bit          stall_armed = 0;
  int          stall_after = 0;
  int          stall_cnt = 0;
  int          words_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes grouped in fours, MSB first; a message of whole words
  // gets an extra empty final word, otherwise the tail word is the final one.
  task automatic model_push(input int n);
    logic [31:0] w;
    int nw, rem;
    nw  = (n + 3) / 4;
    rem = n % 4;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) w = {w[23:0], (4*k + j < n) ? msg_buf[4*k + j] : 8'h00};
      if (k == nw - 1 && rem != 0) exp_q.push_back({1'b1, 2'(rem), w});
      else                         exp_q.push_back({1'b0, 2'b00, w});
    end
    if (rem == 0) exp_q.push_back({1'b1, 2'b00, 32'h0});
  endtask

  task automatic load_str(input string s, output int n);
    n = s.len();
    for (int i = 0; i < n; i++) msg_buf[i] = s[i];
  endtask

  task automatic send_bytes(input int n, input bit with_last);
    int cyc;
    bit acc;
    for (int i = 0; i < n; i++) begin
      if (rand_bf && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        s_byte  = 8'($urandom);
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_byte  = msg_buf[i];
      s_last  = with_last && (i == n - 1);
      cyc = 0;
      acc = 0;
      while (!acc && cyc < 200) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        cyc++;
      end
      check("byte_accept_timeout", 64'(acc), 64'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "_k_in"}, 64'(k_in), 64'd0);
    check({t, "_k_in_ready"}, 64'(k_in_ready), 64'd0);
    check({t, "_k_is_last"}, 64'(k_is_last), 64'd0);
    check({t, "_k_byte_num"}, 64'(k_byte_num), 64'd0);
    check({t, "_s_ready"}, 64'(s_ready), 64'd0);
    check({t, "_busy"}, 64'(busy), 64'd0);
    check({t, "_msg_done"}, 64'(msg_done), 64'd0);
    check({t, "_msg_len"}, 64'(msg_len), 64'd0);
    check({t, "_k_reset"}, 64'(k_reset), 64'd1);
    check({t, "_state"}, 64'(dbg_state), 64'(CRST));
  endtask

  task automatic check_idle(input string t);
    check({t, "_busy"}, 64'(busy), 64'd0);
    check({t, "_k_reset"}, 64'(k_reset), 64'd0);
    check({t, "_s_ready"}, 64'(s_ready), 64'd1);
    check({t, "_k_in_ready"}, 64'(k_in_ready), 64'd0);
  endtask

  // Sends n bytes from msg_buf as one message and walks it through digest wait and core reset.
  task automatic run_msg(input string t, input int n, input bit keep_next);
    bit hold;
    int cyc;
    hold = k_out_ready;
    model_push(n);
    send_bytes(n, 1'b1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({t, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
    done_allowed = 1;
    if (!hold) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        @(posedge clk); #1;
      end
      k_out_ready = 1'b1;
    end
    @(negedge clk);
    check({t, "_msg_len"}, 64'(msg_len), 64'((n > LEN_SAT) ? LEN_SAT : n));
    check({t, "_busy_wait"}, 64'(busy), 64'd1);
    check({t, "_state_wait"}, 64'(dbg_state), 64'(WAIT));
    check({t, "_msg_done"}, 64'(msg_done), 64'd1);
    @(posedge clk); #1;
    done_allowed = 0;
    for (int c = 0; c < RST_CYC; c++) begin
      @(negedge clk);
      check({t, "_crst_k_reset"}, 64'(k_reset), 64'd1);
      check({t, "_crst_busy"}, 64'(busy), 64'd1);
      check({t, "_crst_msg_len"}, 64'(msg_len), 64'd0);
      check({t, "_crst_s_ready"}, 64'(s_ready), 64'd0);
      @(posedge clk); #1;
    end
    k_out_ready = keep_next;
    @(negedge clk);
    check_idle({t, "_idle"});
    @(posedge clk); #1;
  endtask

  initial begin
    k_buffer_full = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        k_buffer_full = 1'b1;
        stall_cnt--;
      end else if (stall_armed && words_seen >= stall_after) begin
        stall_armed   = 0;
        stall_cnt     = 16;
        k_buffer_full = 1'b1;
      end else begin
        k_buffer_full = rand_bf ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(k_in_ready), 64'd1);
        check("hold_word", 64'({k_is_last, k_byte_num, k_in}), 64'(prev_word));
      end
      if (k_in_ready && k_buffer_full) check("s_ready_stall", 64'(s_ready), 64'd0);
      if (k_in_ready && !k_buffer_full) begin
        check("word_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          check("word", 64'({k_is_last, k_byte_num, k_in}), 64'(exp_e));
        end
        words_seen++;
      end
      prev_hold = k_in_ready && k_buffer_full;
      prev_word = {k_is_last, k_byte_num, k_in};
    end
    check("msg_done_pulse", 64'(msg_done), 64'(done_allowed && k_out_ready));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n     = 1'b0;
    s_valid     = 1'b0;
    s_byte      = 8'h00;
    s_last      = 1'b0;
    k_out_ready = 1'b0;

    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (RST_CYC + 2) begin @(posedge clk); #1; end
    @(negedge clk);
    check_idle("start");
    @(posedge clk); #1;

    load_str("abc", n);
    run_msg("abc", n, 1'b0);
    load_str("Hello, world", n);
    run_msg("hello", n, 1'b0);
    load_str("!", n);
    run_msg("bang", n, 1'b0);

    load_str("The quick brown fox.", n);
    words_seen  = 0;
    stall_after = 2;
    stall_armed = 1;
    run_msg("fox", n, 1'b1);

    load_str("SHA3", n);
    run_msg("hold", n, 1'b0);

    k_out_ready = 1'b0;
    load_str("Lorem ipsum", n);
    exp_q.push_back({1'b0, 2'b00, 32'h4C6F7265});
    send_bytes(6, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("lorem_first_word", 64'(exp_q.size()), 64'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (RST_CYC + 2) begin @(posedge clk); #1; end
    @(negedge clk);
    check_idle("after_midrst");
    @(posedge clk); #1;

    load_str("1234567890", n);
    run_msg("digits", n, 1'b0);

    rand_bf = 1;
    for (int m = 0; m < 8; m++) begin
      if (m == 0)      n = 4;
      else if (m == 1) n = 8;
      else if (m == 2) n = 33;
      else             n = $urandom_range(1, 45);
      for (int i = 0; i < n; i++) msg_buf[i] = 8'($urandom);
      run_msg("rand", n, 1'($urandom_range(0, 1)));
    end

    check("queue_empty_end", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
